// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source encodings and the two-way round-robin pick
// used by the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned TAG_WIDTH  = 6;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Single requester wins outright; on a tie the source that did not win last time goes.
  function automatic logic rr_grant(input logic alu_v, input logic mem_v, input logic last_grant);
    logic g;
    g = SRC_ALU;
    if (alu_v && mem_v) begin
      g = ~last_grant;
    end else if (mem_v) begin
      g = SRC_MEM;
    end
    return g;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Synchronous result queue with head peek, occupancy count and a clear that
// empties the queue in one cycle. Push into a full queue is prevented upstream.
module cdb_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Shares one common data bus between the ALU and load/store result producers:
// per-source queues with empty-queue bypass, round-robin grant, registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = TAG_WIDTH,
  parameter int unsigned DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              alu_en,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_en,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              cdb_en,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_src,
  output logic              ovf
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = TAG_W + DATA_W;

  logic [CNT_W-1:0]   alu_count;
  logic [CNT_W-1:0]   mem_count;
  logic [ENTRY_W-1:0] alu_head;
  logic [ENTRY_W-1:0] mem_head;
  logic [ENTRY_W-1:0] alu_entry;
  logic [ENTRY_W-1:0] mem_entry;
  logic [ENTRY_W-1:0] gnt_entry;

  logic active;
  logic queue_clear;
  logic alu_push;
  logic mem_push;
  logic alu_queued;
  logic mem_queued;
  logic alu_cand;
  logic mem_cand;
  logic any_grant;
  logic grant_src;
  logic alu_pop;
  logic mem_pop;
  logic alu_wr;
  logic mem_wr;
  logic drop_seen;

  logic cdb_en_q;
  logic last_grant;

  // Ready looks only at the registered count; a same-cycle pop never frees a slot.
  assign alu_ready = (alu_count < CNT_W'(DEPTH));
  assign mem_ready = (mem_count < CNT_W'(DEPTH));

  assign active      = rdy & ~flush;
  assign queue_clear = rdy & flush;

  assign alu_push = alu_en & alu_ready & active;
  assign mem_push = mem_en & mem_ready & active;

  assign alu_queued = (alu_count != '0);
  assign mem_queued = (mem_count != '0);

  // An empty queue offers the incoming result directly to the arbiter.
  assign alu_cand  = active & (alu_queued | alu_push);
  assign mem_cand  = active & (mem_queued | mem_push);
  assign alu_entry = alu_queued ? alu_head : {alu_tag, alu_data};
  assign mem_entry = mem_queued ? mem_head : {mem_tag, mem_data};

  assign any_grant = alu_cand | mem_cand;
  assign grant_src = rr_grant(alu_cand, mem_cand, last_grant);
  assign gnt_entry = (grant_src == SRC_MEM) ? mem_entry : alu_entry;

  assign alu_pop = any_grant & (grant_src == SRC_ALU) & alu_queued;
  assign mem_pop = any_grant & (grant_src == SRC_MEM) & mem_queued;

  // A bypassed result that wins the grant is broadcast without being stored.
  assign alu_wr = alu_push & (alu_queued | ~any_grant | (grant_src != SRC_ALU));
  assign mem_wr = mem_push & (mem_queued | ~any_grant | (grant_src != SRC_MEM));

  assign drop_seen = (alu_en & ~alu_ready) | (mem_en & ~mem_ready);

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_alu_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clear (queue_clear),
    .push  (alu_wr),
    .pop   (alu_pop),
    .wdata ({alu_tag, alu_data}),
    .head  (alu_head),
    .count (alu_count)
  );

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clear (queue_clear),
    .push  (mem_wr),
    .pop   (mem_pop),
    .wdata ({mem_tag, mem_data}),
    .head  (mem_head),
    .count (mem_count)
  );

  // Broadcast register, round-robin history and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_en_q   <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
      cdb_src    <= SRC_ALU;
      last_grant <= SRC_MEM;
      ovf        <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        cdb_en_q <= 1'b0;
      end else begin
        cdb_en_q <= any_grant;
        if (any_grant) begin
          cdb_tag    <= gnt_entry[ENTRY_W-1:DATA_W];
          cdb_data   <= gnt_entry[DATA_W-1:0];
          cdb_src    <= grant_src;
          last_grant <= grant_src;
        end
        if (drop_seen) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign cdb_en = cdb_en_q & rdy;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of pending results per source.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = TAG_WIDTH;
  localparam int DATA_W  = DATA_WIDTH;
  localparam int ENTRY_W = TAG_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              flush;
  logic              alu_en;
  logic [TAG_W-1:0]  alu_tag;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_en;
  logic [TAG_W-1:0]  mem_tag;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              cdb_en;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_src;
  logic              ovf;

  cdb_arbiter #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .alu_en    (alu_en),
    .alu_tag   (alu_tag),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_en    (mem_en),
    .mem_tag   (mem_tag),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .cdb_en    (cdb_en),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: every accepted result sits in its source list until it is broadcast.
  typedef logic [ENTRY_W-1:0] entry_t;
  entry_t            aq[$];
  entry_t            mq[$];
  logic              m_last_mem;
  logic              m_ovf;
  logic              exp_en;
  logic              exp_src;
  logic [TAG_W-1:0]  exp_tag;
  logic [DATA_W-1:0] exp_data;
  logic              cur_rdy;

  task automatic model_reset();
    aq.delete();
    mq.delete();
    m_last_mem = 1'b1;
    m_ovf      = 1'b0;
    exp_en     = 1'b0;
    exp_src    = 1'b0;
    exp_tag    = '0;
    exp_data   = '0;
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic ae, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad,
                      input logic me, input logic [TAG_W-1:0] mt, input logic [DATA_W-1:0] md,
                      input logic r, input logic f);
    logic   a_ok;
    logic   m_ok;
    logic   pick_mem;
    entry_t e;
    alu_en = ae; alu_tag = at; alu_data = ad;
    mem_en = me; mem_tag = mt; mem_data = md;
    rdy = r; flush = f; cur_rdy = r;
    a_ok = aq.size() < DEPTH;
    m_ok = mq.size() < DEPTH;
    if (r && f) begin
      aq.delete();
      mq.delete();
      exp_en = 1'b0;
    end else if (r) begin
      if ((ae && !a_ok) || (me && !m_ok)) m_ovf = 1'b1;
      if (ae && a_ok) aq.push_back({at, ad});
      if (me && m_ok) mq.push_back({mt, md});
      exp_en = (aq.size() != 0) || (mq.size() != 0);
      if (exp_en) begin
        if (aq.size() == 0)      pick_mem = 1'b1;
        else if (mq.size() == 0) pick_mem = 1'b0;
        else                     pick_mem = !m_last_mem;
        e = pick_mem ? mq.pop_front() : aq.pop_front();
        m_last_mem = pick_mem;
        exp_src    = pick_mem;
        exp_tag    = e[ENTRY_W-1:DATA_W];
        exp_data   = e[DATA_W-1:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, '0, 1'b0, '0, '0, r, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    alu_en = 1'b0; alu_tag = '0; alu_data = '0;
    mem_en = 1'b0; mem_tag = '0; mem_data = '0;
    cur_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({cdb_en, alu_ready, mem_ready, ovf} !== 4'b0110) begin
      n_fail++; $display("FAIL reset_flags got en/ar/mr/ovf=%b exp 0110", {cdb_en, alu_ready, mem_ready, ovf});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if ({cdb_en, alu_ready, mem_ready, ovf} !== 4'b0110) begin
      n_fail++; $display("FAIL post_reset_flags got %b exp 0110", {cdb_en, alu_ready, mem_ready, ovf});
    end
    n_checks++; if (cdb_tag !== '0 || cdb_data !== '0) begin
      n_fail++; $display("FAIL post_reset_bus got tag=%0d data=%h exp 0/0", cdb_tag, cdb_data);
    end
  endtask

  task automatic test_back_to_back();
    int exp_order[8] = '{1, 9, 2, 10, 3, 11, 4, 12};
    int seen[$];
    for (int i = 0; i < 12; i++) begin
      if (i < 4) step(1'b1, TAG_W'(1 + i), DATA_W'($urandom), 1'b1, TAG_W'(9 + i), DATA_W'($urandom), 1'b1, 1'b0);
      else       idle(1'b1);
      n_checks++; if (cdb_en !== exp_en) begin
        n_fail++; $display("FAIL b2b_en cycle %0d got %b exp %b", i, cdb_en, exp_en);
      end
      if (exp_en) begin
        n_checks++; if (cdb_tag !== exp_tag || cdb_data !== exp_data || cdb_src !== exp_src) begin
          n_fail++; $display("FAIL b2b_bus cycle %0d got tag=%0d data=%h src=%b exp tag=%0d data=%h src=%b",
                             i, cdb_tag, cdb_data, cdb_src, exp_tag, exp_data, exp_src);
        end
      end
      if (cdb_en) seen.push_back(int'(cdb_tag));
    end
    n_checks++; if (seen.size() != 8) begin
      n_fail++; $display("FAIL b2b_count got %0d broadcasts exp 8", seen.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++; if (seen[i] != exp_order[i]) begin
          n_fail++; $display("FAIL b2b_order slot %0d got tag %0d exp %0d", i, seen[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, TAG_W'(5), 32'h0000_1234, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (cdb_en !== 1'b1 || cdb_tag !== TAG_W'(5) || cdb_data !== 32'h0000_1234 || cdb_src !== SRC_ALU) begin
      n_fail++; $display("FAIL single_bcast got en=%b tag=%0d data=%h src=%b exp 1/5/00001234/0",
                         cdb_en, cdb_tag, cdb_data, cdb_src);
    end
    idle(1'b1);
    n_checks++; if (cdb_en !== 1'b0) begin
      n_fail++; $display("FAIL single_one_shot got en=%b exp 0", cdb_en);
    end
  endtask

  task automatic test_pause();
    int mem_seen[$];
    for (int i = 0; i < 3; i++) begin
      step(1'b1, TAG_W'(30 + i), DATA_W'($urandom), 1'b1, TAG_W'(20 + i), DATA_W'($urandom), 1'b1, 1'b0);
      if (cdb_en && cdb_src == SRC_MEM) mem_seen.push_back(int'(cdb_tag));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, TAG_W'(40), DATA_W'($urandom), 1'b1, TAG_W'(41), DATA_W'($urandom), 1'b0, 1'b0);
      n_checks++; if (cdb_en !== 1'b0) begin
        n_fail++; $display("FAIL pause_en cycle %0d got %b exp 0", i, cdb_en);
      end
    end
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      n_checks++; if (cdb_en !== exp_en || (exp_en && (cdb_tag !== exp_tag || cdb_src !== exp_src))) begin
        n_fail++; $display("FAIL pause_resume cycle %0d got en=%b tag=%0d src=%b exp en=%b tag=%0d src=%b",
                           i, cdb_en, cdb_tag, cdb_src, exp_en, exp_tag, exp_src);
      end
      if (cdb_en && cdb_src == SRC_MEM) mem_seen.push_back(int'(cdb_tag));
    end
    n_checks++; if (mem_seen.size() != 3 || mem_seen[0] != 20 || mem_seen[1] != 21 || mem_seen[2] != 22) begin
      n_fail++; $display("FAIL pause_mem_order got %0d mem broadcasts, exp tags 20,21,22 in order", mem_seen.size());
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, TAG_W'(44 + i), DATA_W'($urandom), 1'b1, TAG_W'(50 + i), DATA_W'($urandom), 1'b1, 1'b0);
    end
    step(1'b1, TAG_W'(46), DATA_W'($urandom), 1'b1, TAG_W'(52), DATA_W'($urandom), 1'b1, 1'b1);
    n_checks++; if ({cdb_en, alu_ready, mem_ready} !== 3'b011) begin
      n_fail++; $display("FAIL flush_state got en/ar/mr=%b exp 011", {cdb_en, alu_ready, mem_ready});
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      n_checks++; if (cdb_en !== 1'b0) begin
        n_fail++; $display("FAIL flush_leak cycle %0d got en=%b tag=%0d exp en=0", i, cdb_en, cdb_tag);
      end
    end
  endtask

  task automatic test_overflow();
    int  guard = 0;
    logic tag7_seen = 1'b0;
    while (alu_ready && guard < 20) begin
      step(1'b1, TAG_W'(16 + guard), DATA_W'($urandom), mem_ready, TAG_W'(48 + guard), DATA_W'($urandom), 1'b1, 1'b0);
      guard++;
    end
    n_checks++; if (alu_ready !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_fill got alu_ready=%b ovf=%b after %0d cycles exp 0/0", alu_ready, ovf, guard);
    end
    step(1'b1, TAG_W'(7), 32'hDEAD_0007, 1'b0, '0, '0, 1'b1, 1'b0);
    n_checks++; if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set got %b exp 1", ovf);
    end
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (cdb_en && cdb_src == SRC_ALU && cdb_tag == TAG_W'(7)) tag7_seen = 1'b1;
      n_checks++; if (cdb_en !== exp_en || (exp_en && cdb_tag !== exp_tag) || ovf !== 1'b1) begin
        n_fail++; $display("FAIL ovf_drain cycle %0d got en=%b tag=%0d ovf=%b exp en=%b tag=%0d ovf=1",
                           i, cdb_en, cdb_tag, ovf, exp_en, exp_tag);
      end
    end
    n_checks++; if (tag7_seen) begin
      n_fail++; $display("FAIL ovf_dropped got tag 7 broadcast exp never");
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, TAG_W'(33 + i), DATA_W'($urandom), 1'b1, TAG_W'(60 + i), DATA_W'($urandom), 1'b1, 1'b0);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({cdb_en, cdb_src, ovf, alu_ready, mem_ready} !== 5'b00011 || cdb_tag !== '0 || cdb_data !== '0) begin
      n_fail++; $display("FAIL async_reset got en=%b src=%b ovf=%b ar=%b mr=%b tag=%0d data=%h exp 0/0/0/1/1/0/0",
                         cdb_en, cdb_src, ovf, alu_ready, mem_ready, cdb_tag, cdb_data);
    end
    model_reset();
    alu_en = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);
    n_checks++; if (cdb_en !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_lost_queue got en=%b ovf=%b exp 0/0", cdb_en, ovf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), TAG_W'($urandom), DATA_W'($urandom),
           1'($urandom_range(0, 1)), TAG_W'($urandom), DATA_W'($urandom),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 24) == 0));
      n_checks++; if (cdb_en !== (exp_en & cur_rdy)) begin
        n_fail++; $display("FAIL rand_en cycle %0d got %b exp %b", i, cdb_en, exp_en & cur_rdy);
      end
      if (exp_en && cur_rdy) begin
        n_checks++; if (cdb_tag !== exp_tag || cdb_data !== exp_data || cdb_src !== exp_src) begin
          n_fail++; $display("FAIL rand_bus cycle %0d got tag=%0d data=%h src=%b exp tag=%0d data=%h src=%b",
                             i, cdb_tag, cdb_data, cdb_src, exp_tag, exp_data, exp_src);
        end
      end
      n_checks++; if (alu_ready !== (aq.size() < DEPTH) || mem_ready !== (mq.size() < DEPTH) || ovf !== m_ovf) begin
        n_fail++; $display("FAIL rand_status cycle %0d got ar=%b mr=%b ovf=%b exp ar=%b mr=%b ovf=%b",
                           i, alu_ready, mem_ready, ovf, aq.size() < DEPTH, mq.size() < DEPTH, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_pause();
    test_flush();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
